// File: rtl/sn_pkg.sv
// Shared types and sizing for the signal-network request queue.
// Optional statistics counters are enabled by defining SNQ_STATS_EN.
package sn_pkg;

  localparam int unsigned ADDR_WIDTH    = 64;
  localparam int unsigned WL_LEN_BITS   = 8;
  localparam int unsigned SRC_BITS      = 4;
  localparam int unsigned SNQ_DEPTH_DEF = 4;
  localparam int unsigned STAT_CNT_W    = 32;
  localparam int unsigned STAT_ZERO_W   = 16;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  addr;
    logic [WL_LEN_BITS-1:0] len;
    logic [SRC_BITS-1:0]    src;
  } sn_req_t;

  // Active/done control: at most one request in flight and one completion pending.
  typedef enum logic [1:0] {
    SNQ_IDLE   = 2'd0,
    SNQ_ACTIVE = 2'd1,
    SNQ_DONE   = 2'd2
  } snq_state_e;

endpackage

// File: rtl/sn_fifo.sv
// Synchronous first-word-fall-through FIFO of sn_req_t entries.
// Pushes while full and pops while empty are dropped; head reads 0 when empty.
module sn_fifo
  import sn_pkg::*;
#(
  parameter int unsigned DEPTH = SNQ_DEPTH_DEF
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  sn_req_t push_data,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output sn_req_t head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  sn_req_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_en;
  logic               pop_en;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign head    = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sn_req_queue.sv
// Signal-network request queue feeding the tile controller's SN_* port.
// Define SNQ_STATS_EN to add push/completion/zero-length statistics outputs.
module sn_req_queue
  import sn_pkg::*;
#(
  parameter int unsigned DEPTH = SNQ_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   NET_req_valid,
  output logic                   NET_req_ready,
  input  logic [ADDR_WIDTH-1:0]  NET_req_addr,
  input  logic [WL_LEN_BITS-1:0] NET_req_len,
  input  logic [SRC_BITS-1:0]    NET_req_src,
  output logic                   SN_next_op,
  output logic [ADDR_WIDTH-1:0]  SN_next_addr,
  output logic [WL_LEN_BITS-1:0] SN_next_len,
  input  logic                   SN_clr_next,
  input  logic                   SN_req_done,
  output logic                   NET_done_valid,
  output logic [SRC_BITS-1:0]    NET_done_src,
  input  logic                   NET_done_ready,
  output logic                   err_protocol
`ifdef SNQ_STATS_EN
  ,
  output logic [STAT_CNT_W-1:0]  stat_req_cnt,
  output logic [STAT_CNT_W-1:0]  stat_done_cnt,
  output logic [STAT_ZERO_W-1:0] stat_zero_cnt
`endif
);

  snq_state_e          state_q, state_d;
  sn_req_t             push_req;
  sn_req_t             head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic                head_zero;
  logic                next_op_c;
  logic                auto_retire;
  logic                take;
  logic                complete;
  logic                done_hs;
  logic                err_set;
  logic [SRC_BITS-1:0] active_src_q;
  logic [SRC_BITS-1:0] done_src_q;
  logic                err_q;

  assign push_req.addr = NET_req_addr;
  assign push_req.len  = NET_req_len;
  assign push_req.src  = NET_req_src;
  assign fifo_push     = NET_req_valid && !fifo_full;

  sn_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (push_req),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SNQ_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SNQ_IDLE: begin
        if (auto_retire)  state_d = SNQ_DONE;
        else if (take)    state_d = SNQ_ACTIVE;
      end
      SNQ_ACTIVE: if (complete) state_d = SNQ_DONE;
      SNQ_DONE:   if (done_hs)  state_d = SNQ_IDLE;
      default:    state_d = SNQ_IDLE;
    endcase
  end

  // Head is offered or auto-retired only when nothing is active or pending.
  always_comb begin
    head_zero   = 1'b0;
    next_op_c   = 1'b0;
    auto_retire = 1'b0;
    take        = 1'b0;
    complete    = 1'b0;
    done_hs     = 1'b0;
    fifo_pop    = 1'b0;
    err_set     = 1'b0;
    head_zero   = !fifo_empty && (head.len == '0);
    next_op_c   = (state_q == SNQ_IDLE) && !fifo_empty && !head_zero;
    auto_retire = (state_q == SNQ_IDLE) && head_zero;
    take        = SN_clr_next && next_op_c;
    complete    = SN_req_done && (state_q == SNQ_ACTIVE);
    done_hs     = NET_done_ready && (state_q == SNQ_DONE);
    fifo_pop    = auto_retire || take;
    err_set     = (SN_clr_next && !next_op_c) || (SN_req_done && (state_q != SNQ_ACTIVE));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_src_q <= '0;
      done_src_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      if (take)             active_src_q <= head.src;
      if (auto_retire)      done_src_q   <= head.src;
      else if (complete)    done_src_q   <= active_src_q;
      if (err_set)          err_q        <= 1'b1;
    end
  end

  assign NET_req_ready  = !fifo_full;
  assign SN_next_op     = next_op_c;
  assign SN_next_addr   = head.addr;
  assign SN_next_len    = head.len;
  assign NET_done_valid = (state_q == SNQ_DONE);
  assign NET_done_src   = done_src_q;
  assign err_protocol   = err_q;

`ifdef SNQ_STATS_EN
  logic [STAT_CNT_W-1:0]  stat_req_q;
  logic [STAT_CNT_W-1:0]  stat_done_q;
  logic [STAT_ZERO_W-1:0] stat_zero_q;

  // Free-running event counters; wrap silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_req_q  <= '0;
      stat_done_q <= '0;
      stat_zero_q <= '0;
    end else begin
      if (fifo_push)   stat_req_q  <= stat_req_q + STAT_CNT_W'(1);
      if (done_hs)     stat_done_q <= stat_done_q + STAT_CNT_W'(1);
      if (auto_retire) stat_zero_q <= stat_zero_q + STAT_ZERO_W'(1);
    end
  end

  assign stat_req_cnt  = stat_req_q;
  assign stat_done_cnt = stat_done_q;
  assign stat_zero_cnt = stat_zero_q;
`endif

endmodule

// File: tb/tb_sn_req_queue.sv
// Directed self-checking bench for sn_req_queue (works with or without SNQ_STATS_EN).
module tb_sn_req_queue;
  import sn_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   NET_req_valid;
  logic                   NET_req_ready;
  logic [ADDR_WIDTH-1:0]  NET_req_addr;
  logic [WL_LEN_BITS-1:0] NET_req_len;
  logic [SRC_BITS-1:0]    NET_req_src;
  logic                   SN_next_op;
  logic [ADDR_WIDTH-1:0]  SN_next_addr;
  logic [WL_LEN_BITS-1:0] SN_next_len;
  logic                   SN_clr_next;
  logic                   SN_req_done;
  logic                   NET_done_valid;
  logic [SRC_BITS-1:0]    NET_done_src;
  logic                   NET_done_ready;
  logic                   err_protocol;
`ifdef SNQ_STATS_EN
  logic [31:0]            stat_req_cnt;
  logic [31:0]            stat_done_cnt;
  logic [15:0]            stat_zero_cnt;
`endif

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  sn_req_queue #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .NET_req_valid  (NET_req_valid),
    .NET_req_ready  (NET_req_ready),
    .NET_req_addr   (NET_req_addr),
    .NET_req_len    (NET_req_len),
    .NET_req_src    (NET_req_src),
    .SN_next_op     (SN_next_op),
    .SN_next_addr   (SN_next_addr),
    .SN_next_len    (SN_next_len),
    .SN_clr_next    (SN_clr_next),
    .SN_req_done    (SN_req_done),
    .NET_done_valid (NET_done_valid),
    .NET_done_src   (NET_done_src),
    .NET_done_ready (NET_done_ready),
    .err_protocol   (err_protocol)
`ifdef SNQ_STATS_EN
    ,
    .stat_req_cnt   (stat_req_cnt),
    .stat_done_cnt  (stat_done_cnt),
    .stat_zero_cnt  (stat_zero_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] addr, input logic [7:0] len, input logic [3:0] src);
    NET_req_valid = 1'b1;
    NET_req_addr  = addr;
    NET_req_len   = len;
    NET_req_src   = src;
    step();
    NET_req_valid = 1'b0;
  endtask

  // Take the offered head, complete it, and accept the completion (NET_done_ready=1).
  task automatic serve(input logic [63:0] addr, input logic [3:0] src);
    chk("serve_next_op", 64'(SN_next_op), 64'd1);
    chk("serve_addr", SN_next_addr, addr);
    SN_clr_next = 1'b1;
    step();
    SN_clr_next = 1'b0;
    SN_req_done = 1'b1;
    step();
    SN_req_done = 1'b0;
    chk("serve_done_valid", 64'(NET_done_valid), 64'd1);
    chk("serve_done_src", 64'(NET_done_src), 64'(src));
    step();
    chk("serve_done_clear", 64'(NET_done_valid), 64'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    NET_req_valid  = 1'b0;
    NET_req_addr   = '0;
    NET_req_len    = '0;
    NET_req_src    = '0;
    SN_clr_next    = 1'b0;
    SN_req_done    = 1'b0;
    NET_done_ready = 1'b0;
    #12;
    chk("rst_ready", 64'(NET_req_ready), 64'd1);
    chk("rst_next_op", 64'(SN_next_op), 64'd0);
    chk("rst_addr", SN_next_addr, 64'd0);
    chk("rst_len", 64'(SN_next_len), 64'd0);
    chk("rst_done_valid", 64'(NET_done_valid), 64'd0);
    chk("rst_done_src", 64'(NET_done_src), 64'd0);
    chk("rst_err", 64'(err_protocol), 64'd0);
    rst_n = 1'b1;
    step();

    // Single request end to end
    NET_done_ready = 1'b1;
    push(64'h1000, 8'd8, 4'd3);
    chk("t1_next_op", 64'(SN_next_op), 64'd1);
    chk("t1_addr", SN_next_addr, 64'h1000);
    chk("t1_len", 64'(SN_next_len), 64'd8);
    SN_clr_next = 1'b1;
    step();
    SN_clr_next = 1'b0;
    chk("t1_active_no_op", 64'(SN_next_op), 64'd0);
    SN_req_done = 1'b1;
    step();
    SN_req_done = 1'b0;
    chk("t1_done_valid", 64'(NET_done_valid), 64'd1);
    chk("t1_done_src", 64'(NET_done_src), 64'd3);
    step();
    chk("t1_done_one_cycle", 64'(NET_done_valid), 64'd0);

    // Fill to full, back-pressure, pop frees a slot
    push(64'hA0, 8'd1, 4'd8);
    push(64'hA1, 8'd1, 4'd9);
    push(64'hA2, 8'd1, 4'd10);
    push(64'hA3, 8'd1, 4'd11);
    chk("t2_full_ready", 64'(NET_req_ready), 64'd0);
    NET_req_valid = 1'b1;
    NET_req_addr  = 64'hA4;
    NET_req_len   = 8'd1;
    NET_req_src   = 4'd12;
    step();
    chk("t2_held_ready", 64'(NET_req_ready), 64'd0);
    chk("t2_head_kept", SN_next_addr, 64'hA0);
    SN_clr_next = 1'b1;
    step();
    SN_clr_next = 1'b0;
    chk("t2_ready_after_pop", 64'(NET_req_ready), 64'd1);
    chk("t2_active_no_op", 64'(SN_next_op), 64'd0);
    step();
    NET_req_valid = 1'b0;
    chk("t2_refull_ready", 64'(NET_req_ready), 64'd0);
    SN_req_done = 1'b1;
    step();
    SN_req_done = 1'b0;
    chk("t2_done_src", 64'(NET_done_src), 64'd8);
    step();
    serve(64'hA1, 4'd9);
    serve(64'hA2, 4'd10);
    serve(64'hA3, 4'd11);
    serve(64'hA4, 4'd12);
    chk("t2_drained_next_op", 64'(SN_next_op), 64'd0);

    // Zero-length auto-retire followed by a normal entry
    push(64'h0, 8'd0, 4'd5);
    chk("t3_zero_no_op", 64'(SN_next_op), 64'd0);
    push(64'h2000, 8'd2, 4'd6);
    chk("t3_zero_done_valid", 64'(NET_done_valid), 64'd1);
    chk("t3_zero_done_src", 64'(NET_done_src), 64'd5);
    chk("t3_zero_still_no_op", 64'(SN_next_op), 64'd0);
    step();
    chk("t3_next_op", 64'(SN_next_op), 64'd1);
    chk("t3_next_addr", SN_next_addr, 64'h2000);
    chk("t3_next_len", 64'(SN_next_len), 64'd2);

    // Completion back-pressure holds next head off
    SN_clr_next = 1'b1;
    step();
    SN_clr_next = 1'b0;
    push(64'h3000, 8'd1, 4'd7);
    NET_done_ready = 1'b0;
    SN_req_done = 1'b1;
    step();
    SN_req_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 64'(NET_done_valid), 64'd1);
      chk("t4_hold_src", 64'(NET_done_src), 64'd6);
      chk("t4_hold_no_op", 64'(SN_next_op), 64'd0);
      step();
    end
    NET_done_ready = 1'b1;
    step();
    chk("t4_release_valid", 64'(NET_done_valid), 64'd0);
    chk("t4_release_next_op", 64'(SN_next_op), 64'd1);
    chk("t4_release_addr", SN_next_addr, 64'h3000);
    serve(64'h3000, 4'd7);

    // Protocol errors are ignored and sticky
    chk("t5_err_clean", 64'(err_protocol), 64'd0);
    SN_req_done = 1'b1;
    step();
    SN_req_done = 1'b0;
    chk("t5_err_done", 64'(err_protocol), 64'd1);
    chk("t5_no_done", 64'(NET_done_valid), 64'd0);
    SN_clr_next = 1'b1;
    step();
    SN_clr_next = 1'b0;
    chk("t5_err_clr", 64'(err_protocol), 64'd1);
    chk("t5_ready", 64'(NET_req_ready), 64'd1);
    chk("t5_no_op", 64'(SN_next_op), 64'd0);
    push(64'h4000, 8'd3, 4'd1);
    serve(64'h4000, 4'd1);
    chk("t5_err_sticky", 64'(err_protocol), 64'd1);

    // Async reset with 3 queued and a pending completion
    push(64'hB0, 8'd1, 4'd2);
    push(64'hB1, 8'd1, 4'd2);
    push(64'hB2, 8'd1, 4'd2);
    push(64'hB3, 8'd1, 4'd2);
    SN_clr_next = 1'b1;
    step();
    SN_clr_next = 1'b0;
    NET_done_ready = 1'b0;
    SN_req_done = 1'b1;
    step();
    SN_req_done = 1'b0;
    chk("t6_pending", 64'(NET_done_valid), 64'd1);
`ifdef SNQ_STATS_EN
    chk("stat_req", 64'(stat_req_cnt), 64'd14);
    chk("stat_done", 64'(stat_done_cnt), 64'd10);
    chk("stat_zero", 64'(stat_zero_cnt), 64'd1);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", 64'(NET_req_ready), 64'd1);
    chk("t6_rst_next_op", 64'(SN_next_op), 64'd0);
    chk("t6_rst_addr", SN_next_addr, 64'd0);
    chk("t6_rst_len", 64'(SN_next_len), 64'd0);
    chk("t6_rst_done_valid", 64'(NET_done_valid), 64'd0);
    chk("t6_rst_done_src", 64'(NET_done_src), 64'd0);
    chk("t6_rst_err", 64'(err_protocol), 64'd0);
`ifdef SNQ_STATS_EN
    chk("t6_rst_stat_req", 64'(stat_req_cnt), 64'd0);
`endif
    step();
    rst_n = 1'b1;
    NET_done_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_post_no_done", 64'(NET_done_valid), 64'd0);
      chk("t6_post_no_op", 64'(SN_next_op), 64'd0);
    end
    chk("t6_post_ready", 64'(NET_req_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
